tmds_decoder: RTL

//  Receive-side counterpart of tmds_encoder: takes raw 10-bit words from a 1:10 deserializer (arbitrary word phase).
//  Bit-slips to the symbol boundary using DVI control tokens, then decodes symbols to 8-bit pixel data or 2-bit control.
//  One instance per channel (blue carries {vsync,hsync} on control_out); feeds a capture/frame-buffer writer.

---
 rtl/tmds_pkg.sv | 17 +
 rtl/tmds_bitslip.sv | 31 +++
 rtl/tmds_decoder.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/tmds_pkg.sv
// Shared constants and types for the TMDS receive path: DVI control tokens,
// aligner state encoding and bit-slip offset width.
package tmds_pkg;

   localparam int SLIP_W = 4;

   localparam logic [9:0] TOK_C00 = 10'b1101010100;
   localparam logic [9:0] TOK_C01 = 10'b0010101011;
   localparam logic [9:0] TOK_C10 = 10'b0101010100;
   localparam logic [9:0] TOK_C11 = 10'b1010101011;

   typedef enum logic {
      SEARCH = 1'b0,
      LOCKED = 1'b1
   } tmds_state_e;

endpackage

// File: rtl/tmds_bitslip.sv
// Word aligner: keeps the previous deserializer word and selects a 10-bit
// symbol out of the 20-bit two-word window at the requested slip offset.
module tmds_bitslip
   import tmds_pkg::*;
(
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic [9:0]        tmds_in,
   input  logic [SLIP_W-1:0] slip,
   output logic [9:0]        sym_p1
);

   logic [9:0]  word_p0;
   logic [19:0] window;

   // Older word sits in the low half, so offset s takes the tail of the old word
   // followed by the head of the new one.
   assign window = {tmds_in, word_p0};

   // stage 0 -> stage 1
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         word_p0 <= '0;
         sym_p1  <= '0;
      end else begin
         word_p0 <= tmds_in;
         sym_p1  <= window[slip +: 10];
      end
   end

endmodule

// File: rtl/tmds_decoder.sv
// TMDS channel decoder: bit-slip alignment on DVI control tokens, then 8b/10b
// data / 2-bit control decode. Optional lock-loss counter: TMDS_LOCK_STATS_EN.
module tmds_decoder
   import tmds_pkg::*;
#(
   parameter int LOCK_COUNT     = 8,
   parameter int SEARCH_TIMEOUT = 2048,
   parameter int LOSS_TIMEOUT   = 4096
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic [9:0]        tmds_in,
   output logic [7:0]        data_out,
   output logic [1:0]        control_out,
   output logic              de_out,
   output logic              locked_out,
`ifdef TMDS_LOCK_STATS_EN
   output logic [15:0]       lock_loss_cnt_out,
`endif
   output logic [SLIP_W-1:0] slip_out
);

   localparam int TOK_W  = $clog2(LOCK_COUNT + 1);
   localparam int SRCH_W = $clog2(SEARCH_TIMEOUT + 1);
   localparam int LOSS_W = $clog2(LOSS_TIMEOUT + 1);
   localparam int TMR_W  = (SRCH_W > LOSS_W) ? SRCH_W : LOSS_W;

   localparam logic [TOK_W-1:0] TOK_LAST    = TOK_W'(LOCK_COUNT - 1);
   localparam logic [TMR_W-1:0] SEARCH_LAST = TMR_W'(SEARCH_TIMEOUT - 1);
   localparam logic [TMR_W-1:0] LOSS_LAST   = TMR_W'(LOSS_TIMEOUT - 1);

   // {hit, c1, c0}
   function automatic logic [2:0] match_token(input logic [9:0] sym);
      case (sym)
         TOK_C00: return 3'b100;
         TOK_C01: return 3'b101;
         TOK_C10: return 3'b110;
         TOK_C11: return 3'b111;
         default: return 3'b000;
      endcase
   endfunction

   function automatic logic [7:0] decode_data(input logic [9:0] sym);
      logic [7:0] q;
      logic [7:0] d;
      q    = sym[9] ? ~sym[7:0] : sym[7:0];
      d[0] = q[0];
      for (int i = 1; i < 8; i++)
         d[i] = sym[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
      return d;
   endfunction

   logic [9:0]        sym_p1;
   logic [2:0]        tok_p1;
   logic              tok_hit;

   tmds_state_e       state_q, state_d;
   logic [SLIP_W-1:0] slip_q, slip_d;
   logic [TOK_W-1:0]  tok_cnt_q, tok_cnt_d;
   logic [TMR_W-1:0]  tmr_q, tmr_d;
   logic              skip_q, skip_d;

   tmds_bitslip u_bitslip (
      .clk_in  (clk_in),
      .rst_in  (rst_in),
      .tmds_in (tmds_in),
      .slip    (slip_q),
      .sym_p1  (sym_p1)
   );

   assign tok_p1  = match_token(sym_p1);
   assign tok_hit = tok_p1[2];

   always_comb begin
      state_d   = state_q;
      slip_d    = slip_q;
      tok_cnt_d = tok_cnt_q;
      tmr_d     = tmr_q;
      skip_d    = 1'b0;
      case (state_q)
         SEARCH: begin
            tmr_d = tmr_q + 1'b1;
            // sym_p1 right after a slip was cut at the old offset; don't count it
            if (!skip_q)
               tok_cnt_d = tok_hit ? tok_cnt_q + 1'b1 : '0;
            if (!skip_q && tok_hit && tok_cnt_q == TOK_LAST) begin
               state_d   = LOCKED;
               tok_cnt_d = '0;
               tmr_d     = '0;
            end else if (tmr_q == SEARCH_LAST) begin
               slip_d    = (slip_q == SLIP_W'(9)) ? '0 : slip_q + 1'b1;
               tok_cnt_d = '0;
               tmr_d     = '0;
               skip_d    = 1'b1;
            end
         end
         LOCKED: begin
            if (tok_hit) begin
               tmr_d = '0;
            end else if (tmr_q == LOSS_LAST) begin
               state_d   = SEARCH;
               tok_cnt_d = '0;
               tmr_d     = '0;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         default: state_d = SEARCH;
      endcase
   end

   // stage 1 -> stage 2
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q     <= SEARCH;
         slip_q      <= '0;
         tok_cnt_q   <= '0;
         tmr_q       <= '0;
         skip_q      <= 1'b0;
         data_out    <= '0;
         control_out <= '0;
         de_out      <= 1'b0;
         locked_out  <= 1'b0;
      end else begin
         state_q    <= state_d;
         slip_q     <= slip_d;
         tok_cnt_q  <= tok_cnt_d;
         tmr_q      <= tmr_d;
         skip_q     <= skip_d;
         locked_out <= (state_q == LOCKED);
         if (state_q == LOCKED) begin
            de_out      <= !tok_hit;
            data_out    <= tok_hit ? 8'h00 : decode_data(sym_p1);
            control_out <= tok_hit ? tok_p1[1:0] : 2'b00;
         end else begin
            de_out      <= 1'b0;
            data_out    <= '0;
            control_out <= '0;
         end
      end
   end

   assign slip_out = slip_q;

`ifdef TMDS_LOCK_STATS_EN
   logic [15:0] loss_cnt_q;

   always_ff @(posedge clk_in) begin
      if (rst_in)
         loss_cnt_q <= '0;
      else if (state_q == LOCKED && state_d == SEARCH && loss_cnt_q != 16'hFFFF)
         loss_cnt_q <= loss_cnt_q + 16'd1;
   end

   assign lock_loss_cnt_out = loss_cnt_q;
`endif

endmodule
